// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared encodings and defaults for the data-memory responder
package dmem_responder_pkg;

  localparam int BUS_WIDTH_DEF = 64;
  localparam int MEM_LEN_DEF   = 12;
  localparam int MEM_BIT_WIDTH = 2;
  localparam int LATENCY_DEF   = 2;
  localparam int CNT_W         = 4;

  typedef enum logic [MEM_BIT_WIDTH-1:0] {
    MEM_BYTE   = 2'd0,
    MEM_HALF   = 2'd1,
    MEM_WORD   = 2'd2,
    MEM_DOUBLE = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Byte lanes touched by an access of the given size, relative to its base address.
  function automatic logic [7:0] size_mask(input logic [MEM_BIT_WIDTH-1:0] size);
    case (size)
      MEM_BYTE: size_mask = 8'h01;
      MEM_HALF: size_mask = 8'h03;
      MEM_WORD: size_mask = 8'h0f;
      default:  size_mask = 8'hff;
    endcase
  endfunction

  // An access is misaligned when its address is not a multiple of its size.
  function automatic logic is_misaligned(input logic [MEM_BIT_WIDTH-1:0] size,
                                         input logic [2:0] addr_lo);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = addr_lo[0];
      MEM_WORD: is_misaligned = |addr_lo[1:0];
      default:  is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage load/store request and response bundle
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) ();

  logic                     req_valid;
  logic                     req_write;
  logic [MEM_BIT_WIDTH-1:0] req_size;
  logic                     req_unsigned;
  logic [BUS_WIDTH-1:0]     req_addr;
  logic [BUS_WIDTH-1:0]     req_wdata;
  logic                     stall;
  logic                     ack;
  logic [BUS_WIDTH-1:0]     rdata;
  logic                     err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  stall, ack, rdata, err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output stall, ack, rdata, err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - byte-lane RAM with per-byte write mask and wrapping combinational read
module dmem_array #(
  parameter int BUS_WIDTH = 64,
  parameter int MEM_LEN   = 12
) (
  input  logic                   clk,
  input  logic [MEM_LEN-1:0]     addr,
  input  logic [BUS_WIDTH/8-1:0] we,
  input  logic [BUS_WIDTH-1:0]   wdata,
  output logic [BUS_WIDTH-1:0]   rdata
);

  localparam int NB = BUS_WIDTH / 8;

  // Contents are deliberately not reset; the array starts out zeroed.
  logic [7:0] mem_q [2**MEM_LEN] = '{default: 8'h00};

  // Byte-lane writes; lane addresses wrap inside the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem_q[addr + MEM_LEN'(i)] <= wdata[8*i +: 8];
    end
  end

  // Read a full bus word starting at the base address, little-endian.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NB; i++) begin
      rdata[8*i +: 8] = mem_q[addr + MEM_LEN'(i)];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory target driving the pipeline stall line
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int MEM_LEN   = MEM_LEN_DEF,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  dmem_responder_if.slave    bus
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [BUS_WIDTH-1:0]   rd_raw;
  logic [BUS_WIDTH-1:0]   ld_ext;
  logic [BUS_WIDTH/8-1:0] we;
  logic                   misaligned;
  logic                   fire;
  logic                   unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[BUS_WIDTH-1:MEM_LEN];

  dmem_array #(.BUS_WIDTH(BUS_WIDTH), .MEM_LEN(MEM_LEN)) u_array (
    .clk   (clk),
    .addr  (bus.req_addr[MEM_LEN-1:0]),
    .we    (we),
    .wdata (bus.req_wdata),
    .rdata (rd_raw)
  );

  // Access decode: alignment, the access edge, store lanes and load extension.
  always_comb begin
    misaligned = is_misaligned(bus.req_size, bus.req_addr[2:0]);
    fire       = (state_q == S_BUSY) && bus.req_valid && (cnt_q == '0);
    we         = '0;
    if (fire && bus.req_write && !misaligned) we = (BUS_WIDTH/8)'(size_mask(bus.req_size));
    case (bus.req_size)
      MEM_BYTE: ld_ext = {{(BUS_WIDTH-8){rd_raw[7] & ~bus.req_unsigned}}, rd_raw[7:0]};
      MEM_HALF: ld_ext = {{(BUS_WIDTH-16){rd_raw[15] & ~bus.req_unsigned}}, rd_raw[15:0]};
      MEM_WORD: ld_ext = {{(BUS_WIDTH-32){rd_raw[31] & ~bus.req_unsigned}}, rd_raw[31:0]};
      default:  ld_ext = rd_raw;
    endcase
  end

  // State, wait counter and registered response; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state: count down the latency, then capture the response on the access edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      S_BUSY: begin
        if (!bus.req_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_RESP;
          rdata_d = misaligned ? '0 : ld_ext;
          err_d   = misaligned;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: stall drops in the response cycle so the pipeline advances on that edge.
  always_comb begin
    bus.stall = bus.req_valid && (state_q != S_RESP);
    bus.ack   = (state_q == S_RESP);
    bus.rdata = rdata_q;
    bus.err   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a byte-array model
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int LAT = 2;
  localparam int ML  = 12;
  localparam int MSZ = 1 << ML;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.BUS_WIDTH(64)) bus ();

  dmem_responder #(.BUS_WIDTH(64), .MEM_LEN(ML), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  byte unsigned      mem_m [MSZ];
  logic [65:0]       exp_q [$];
  longint unsigned   cyc = 0;
  longint unsigned   ack_t [$];

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endfunction

  // Reference: {check_data, err, rdata}. Applies stores to the model as they are issued.
  function automatic logic [65:0] model(input bit w, input int size, input bit uns,
                                        input longint unsigned addr, input longint unsigned wd);
    int n = 1 << size;
    longint unsigned a = addr % MSZ;
    longint unsigned v = 0;
    if ((addr % n) != 0) return {1'b1, 1'b1, 64'h0};
    if (w) begin
      for (int i = 0; i < n; i++) mem_m[(a + i) % MSZ] = 8'(wd >> (8 * i));
      return {1'b0, 1'b0, 64'h0};
    end
    for (int i = 0; i < n; i++) v |= longint'(mem_m[(a + i) % MSZ]) << (8 * i);
    if (!uns && n < 8 && ((v >> (8 * n - 1)) & 1) == 1) v |= ~((64'd1 << (8 * n)) - 1);
    return {1'b1, 1'b0, v};
  endfunction

  // Monitor: every acknowledge must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.ack === 1'b1) begin
      ack_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'd1, 64'd0);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        check("err", 64'(bus.err), 64'(e[64]));
        if (e[65]) check("rdata", bus.rdata, e[63:0]);
      end
    end
  end

  task automatic drive(input bit w, input int size, input bit uns,
                       input longint unsigned addr, input longint unsigned wd);
    bus.req_write    = w;
    bus.req_size     = 2'(size);
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
  endtask

  // Issue one access, check stall each cycle and the ack latency, then optionally idle a cycle.
  task automatic access(input bit w, input int size, input bit uns,
                        input longint unsigned addr, input longint unsigned wd, input bit drop);
    int  n;
    bit  got;
    exp_q.push_back(model(w, size, uns, addr, wd));
    drive(w, size, uns, addr, wd);
    n   = 0;
    got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        got = 1;
        check("latency", 64'(n), 64'(LAT + 1));
        check("stall_at_ack", 64'(bus.stall), 64'd0);
      end else begin
        check("stall_busy", 64'(bus.stall), 64'd1);
      end
      n++;
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (drop) begin
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) mem_m[i] = 8'h00;
    drive(0, 3, 0, 0, 0);

    // Reset held with a request pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_stall", 64'(bus.stall), 64'd1);
      check("rst_ack", 64'(bus.ack), 64'd0);
      check("rst_rdata", bus.rdata, 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    access(0, 3, 0, 0, 0, 1);

    // Store then load.
    access(1, 3, 0, 64'h10, 64'h1122334455667788, 1);
    access(0, 3, 0, 64'h10, 0, 1);

    // Extension.
    access(1, 3, 0, 64'h20, 64'h00000000000080ff, 1);
    access(0, 0, 0, 64'h20, 0, 1);
    access(0, 0, 1, 64'h20, 0, 1);
    access(0, 1, 0, 64'h20, 0, 1);
    access(0, 2, 1, 64'h20, 0, 1);

    // Misalignment.
    access(1, 2, 0, 64'h22, 64'hdeadbeefcafef00d, 1);
    access(0, 3, 0, 64'h20, 0, 1);
    access(0, 2, 0, 64'h21, 0, 1);

    // Back-to-back with the request held continuously.
    access(0, 3, 0, 64'h10, 0, 0);
    access(0, 3, 0, 64'h20, 0, 1);
    if (ack_t.size() >= 2) check("b2b_spacing", ack_t[$] - ack_t[$-1], 64'd4);
    else check("b2b_acks", 64'(ack_t.size()), 64'd2);

    // Request dropped mid-BUSY: no ack, no write.
    drive(1, 3, 0, 64'h30, 64'h5555aaaa5555aaaa);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_stall", 64'(bus.stall), 64'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_ack", 64'(bus.ack), 64'd0);
    end
    @(posedge clk); #1;
    access(0, 3, 0, 64'h30, 0, 1);

    // Address wrap.
    access(1, 0, 0, 64'(MSZ + 5), 64'hab, 1);
    access(0, 0, 0, 64'h5, 0, 1);

    // Reset before the access edge: store lost.
    drive(1, 3, 0, 64'h40, 64'h0123456789abcdef);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    access(0, 3, 0, 64'h40, 0, 1);

    // Reset in the response cycle: store retained, ack suppressed.
    drive(1, 3, 0, 64'h48, 64'hfedcba9876543210);
    void'(model(1, 3, 0, 64'h48, 64'hfedcba9876543210));
    repeat (LAT + 1) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_resp_ack", 64'(bus.ack), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(0, 3, 0, 64'h48, 0, 1);

    // Randomized traffic over a small window with aliasing upper bits.
    for (int k = 0; k < 200; k++) begin
      int              sz;
      longint unsigned ad;
      sz = int'($urandom_range(3, 0));
      ad = longint'($urandom_range(63, 0));
      if ($urandom_range(3, 0) != 0) ad = ad & ~longint'((1 << sz) - 1);
      ad = ad | (longint'($urandom_range(3, 0)) << ML);
      access(bit'($urandom_range(1, 0)), sz, bit'($urandom_range(1, 0)), ad,
             {$urandom, $urandom}, bit'($urandom_range(1, 0)));
    end

    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
